// File: rtl/perceptron_trainer_if.sv
// Execute-to-trainer branch bundle and trainer-to-table write port.
// master: drives ex_*/stall, sees up_*; slave: the trainer.
interface perceptron_trainer_if #(
  parameter int NUM_W = 12,
  parameter int HOB_W = 3,
  parameter int LOB_W = 5,
  parameter int IDX_W = 6
);
  logic                   stall;
  logic                   ex_valid;
  logic [31:0]            ex_pc;
  logic                   ex_dir;
  logic [NUM_W-1:0]       ex_ghr;
  logic [NUM_W*HOB_W-1:0] ex_hob;
  logic [NUM_W*LOB_W-1:0] ex_lob;
  logic                   up_wren;
  logic [IDX_W-1:0]       up_addr;
  logic [NUM_W*HOB_W-1:0] up_hob_data;
  logic [NUM_W*LOB_W-1:0] up_lob_data;

  modport master (
    output stall, ex_valid, ex_pc, ex_dir,
    output ex_ghr, ex_hob, ex_lob,
    input  up_wren, up_addr,
    input  up_hob_data, up_lob_data
  );

  modport slave (
    input  stall, ex_valid, ex_pc, ex_dir,
    input  ex_ghr, ex_hob, ex_lob,
    output up_wren, up_addr,
    output up_hob_data, up_lob_data
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: clears HOB/LOB tables after reset, then trains.
// Ports: clk, reset (sync, high), bus (slave), busy, train_count.
module perceptron_trainer #(
  parameter int NUM_W   = 12,
  parameter int HOB_W   = 3,
  parameter int LOB_W   = 5,
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int THETA   = 37
) (
  input  logic                 clk,
  input  logic                 reset,
  perceptron_trainer_if.slave  bus,
  output logic                 busy,
  output logic [31:0]          train_count
);
  localparam int WW = HOB_W + LOB_W;
  localparam int YW = 12;
  localparam logic signed [WW-1:0] WMAX = {1'b0, {(WW-1){1'b1}}};
  localparam logic signed [WW-1:0] WMIN = {1'b1, {(WW-1){1'b0}}};

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic             clr_wr, cap;

  logic [IDX_W-1:0]        in_addr;
  logic                    fwd_s1, fwd_up;
  logic signed [WW-1:0]    ex_w  [NUM_W];
  logic signed [WW-1:0]    up_w  [NUM_W];
  logic signed [WW-1:0]    fw_w  [NUM_W];
  logic signed [YW-1:0]    y_nx;

  logic                    s1_valid, s1_dir;
  logic [NUM_W-1:0]        s1_ghr;
  logic [IDX_W-1:0]        s1_addr;
  logic signed [WW-1:0]    s1_w  [NUM_W];
  logic signed [WW-1:0]    s1_wn [NUM_W];
  logic signed [YW-1:0]    s1_y, s1_abs;
  logic                    s1_pred, s1_train;
  logic [NUM_W*HOB_W-1:0]  nx_hob;
  logic [NUM_W*LOB_W-1:0]  nx_lob;

  logic unused_pc;
  assign unused_pc = ^{bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (idx == IDX_W'(ENTRIES-1)) state_nx = RUN;
      RUN:   state_nx = RUN;
    endcase
  end

  always_comb begin
    clr_wr = (state == CLEAR);
    cap    = (state == RUN) & bus.ex_valid & ~bus.stall;
  end

  always_ff @(posedge clk) begin
    if (reset)       idx <= '0;
    else if (clr_wr) idx <= idx + IDX_W'(1);
  end

  // Newest copy of the weights wins: S1 result, then output reg.
  always_comb begin
    in_addr = bus.ex_pc[IDX_W+1:2];
    fwd_s1  = s1_valid & s1_train & (s1_addr == in_addr);
    fwd_up  = bus.up_wren & (bus.up_addr == in_addr);
    y_nx    = '0;
    for (int i = 0; i < NUM_W; i++) begin
      ex_w[i] = {bus.ex_hob[HOB_W*i +: HOB_W],
                 bus.ex_lob[LOB_W*i +: LOB_W]};
      up_w[i] = {bus.up_hob_data[HOB_W*i +: HOB_W],
                 bus.up_lob_data[LOB_W*i +: LOB_W]};
      fw_w[i] = fwd_s1 ? s1_wn[i] :
                fwd_up ? up_w[i]  : ex_w[i];
      if (bus.ex_ghr[i]) y_nx = y_nx + YW'(fw_w[i]);
      else               y_nx = y_nx - YW'(fw_w[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= cap;
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      s1_dir  <= bus.ex_dir;
      s1_ghr  <= bus.ex_ghr;
      s1_addr <= in_addr;
      s1_w    <= fw_w;
      s1_y    <= y_nx;
    end
  end

  always_comb begin
    s1_pred  = ~s1_y[YW-1];
    s1_abs   = s1_y[YW-1] ? -s1_y : s1_y;
    s1_train = (s1_pred != s1_dir) | (s1_abs <= YW'(THETA));
    nx_hob   = '0;
    nx_lob   = '0;
    for (int i = 0; i < NUM_W; i++) begin
      if (s1_ghr[i] == s1_dir)
        s1_wn[i] = (s1_w[i] == WMAX) ? s1_w[i]
                                     : s1_w[i] + WW'(1);
      else
        s1_wn[i] = (s1_w[i] == WMIN) ? s1_w[i]
                                     : s1_w[i] - WW'(1);
      nx_hob[HOB_W*i +: HOB_W] = s1_wn[i][WW-1:LOB_W];
      nx_lob[LOB_W*i +: LOB_W] = s1_wn[i][LOB_W-1:0];
    end
  end

  // busy trails the state so it covers the final clear write.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy            <= 1'b1;
      bus.up_wren     <= 1'b0;
      bus.up_addr     <= '0;
      bus.up_hob_data <= '0;
      bus.up_lob_data <= '0;
      train_count     <= '0;
    end else begin
      busy <= clr_wr;
      if (clr_wr) begin
        bus.up_wren     <= 1'b1;
        bus.up_addr     <= idx;
        bus.up_hob_data <= '0;
        bus.up_lob_data <= '0;
      end else begin
        bus.up_wren <= s1_valid & s1_train;
        if (s1_valid & s1_train) begin
          bus.up_addr     <= s1_addr;
          bus.up_hob_data <= nx_hob;
          bus.up_lob_data <= nx_lob;
          train_count     <= train_count + 32'd1;
        end
      end
    end
  end
endmodule
